// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply/divide unit for the EX stage: 32-cycle shift-add
// multiply and restoring divide, with pipeline stall and flush handling.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  reg_dst,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [3:0]  reg_dst_out,
  output logic        stall_req
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11} op_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  op_t         r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_dst;
  logic [63:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_quo;

  logic        w_accept;
  logic        w_divzero;
  logic        w_last;
  logic [32:0] w_mul_sum;
  logic [63:0] w_prod_nxt;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_busy_res;
  logic [31:0] w_zero_res;

  assign w_accept  = (r_state == S_IDLE) && start && !flush;
  assign w_divzero = op[1] && (src_b == '0);
  assign w_last    = (r_cnt == 6'd31);

  // Multiply: upper half accumulates, lower half shifts the multiplier out.
  assign w_mul_sum  = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_a} : 33'd0);
  assign w_prod_nxt = {w_mul_sum, r_prod[31:1]};

  // Restoring divide: a borrow in bit 32 means the trial subtraction failed.
  assign w_div_shift = {r_rem, r_quo[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_rem_nxt   = w_div_diff[32] ? w_div_shift[31:0] : w_div_diff[31:0];
  assign w_quo_nxt   = {r_quo[30:0], ~w_div_diff[32]};

  assign w_zero_res = op[0] ? src_a : '1;

  always_comb begin
    w_busy_res = '0;
    unique case (r_op)
      OP_MUL:   w_busy_res = w_prod_nxt[31:0];
      OP_MULHU: w_busy_res = w_prod_nxt[63:32];
      OP_DIVU:  w_busy_res = w_quo_nxt;
      OP_REMU:  w_busy_res = w_rem_nxt;
      default:  w_busy_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_next    = w_divzero ? S_DONE : S_BUSY;
          stall_req = rst_n;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (flush)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        result_valid = !flush;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_op   <= OP_MUL;
      r_a    <= '0;
      r_b    <= '0;
      r_dst  <= '0;
      r_prod <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_op   <= op_t'(op);
      r_a    <= src_a;
      r_b    <= src_b;
      r_dst  <= reg_dst;
      r_prod <= {32'd0, src_b};
      r_rem  <= '0;
      r_quo  <= src_a;
    end else if (r_state == S_BUSY) begin
      if (!w_last) r_cnt <= r_cnt + 6'd1;
      if (r_op[1]) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end else begin
        r_prod <= w_prod_nxt;
      end
    end
  end

  // Result is loaded from the final iteration's next-values so it is ready on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      reg_dst_out <= '0;
    end else if (w_accept && w_divzero) begin
      result      <= w_zero_res;
      reg_dst_out <= reg_dst;
    end else if ((r_state == S_BUSY) && !flush && w_last) begin
      result      <= w_busy_res;
      reg_dst_out <= r_dst;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, flush/reset
// sequences, and randomized operations against an arithmetic reference.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  reg_dst;
  logic [31:0] result;
  logic        result_valid;
  logic [3:0]  reg_dst_out;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  ex_muldiv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .start        (start),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .reg_dst      (reg_dst),
    .result       (result),
    .result_valid (result_valid),
    .reg_dst_out  (reg_dst_out),
    .stall_req    (stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  dst;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op at the next negedge and follow it to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] d, input logic [31:0] er, input int el, input bit junk);
    int lat;
    bit stall_ok;
    @(negedge clk);
    op = o; src_a = a; src_b = b; reg_dst = d; start = 1'b1; flush = 1'b0;
    #1 stall_ok = (stall_req === 1'b1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (stall_req !== 1'b1) stall_ok = 1'b0;
      if (junk) begin
        start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom; reg_dst = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(el));
    chk("result", {32'd0, result}, {32'd0, er});
    chk("reg_dst_out", {60'd0, reg_dst_out}, {60'd0, d});
    chk("stall_while_busy", {63'd0, stall_ok}, 64'd1);
    chk("stall_in_done", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    chk("idle_after_done", {62'd0, result_valid, stall_req}, 64'd0);
    chk("result_hold", {32'd0, result}, {32'd0, er});
  endtask

  vec_t vecs[$];
  logic [31:0] prev_res;
  logic [3:0]  prev_dst;
  bit          no_valid;

  initial begin
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; reg_dst = '0;
    #1;
    chk("reset_outputs", {result, reg_dst_out, result_valid, stall_req}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{2'd0, 32'd7,          32'd6,          4'd3,  32'd42,         33});
    vecs.push_back('{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd5,  32'hFFFF_FFFE,  33});
    vecs.push_back('{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd6,  32'h0000_0001,  33});
    vecs.push_back('{2'd2, 32'd100,        32'd7,          4'd7,  32'd14,         33});
    vecs.push_back('{2'd3, 32'd100,        32'd7,          4'd8,  32'd2,          33});
    vecs.push_back('{2'd2, 32'd5,          32'd0,          4'd9,  32'hFFFF_FFFF,  1});
    vecs.push_back('{2'd3, 32'd5,          32'd0,          4'd10, 32'd5,          1});
    vecs.push_back('{2'd2, 32'd3,          32'hFFFF_FFFF,  4'd11, 32'd0,          33});
    vecs.push_back('{2'd3, 32'hFFFF_FFFF,  32'd1,          4'd12, 32'd0,          33});
    vecs.push_back('{2'd1, 32'h8000_0000,  32'd4,          4'd13, 32'd2,          33});
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].exp_res, vecs[i].exp_lat, i[0]);

    // flush and start together in IDLE: no capture, no stall
    prev_res = result; prev_dst = reg_dst_out;
    @(negedge clk);
    op = 2'd0; src_a = 32'd3; src_b = 32'd3; reg_dst = 4'd1; start = 1'b1; flush = 1'b1;
    #1 chk("flush_start_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 chk("flush_start_stays_idle", {62'd0, stall_req, result_valid}, 64'd0);

    // flush at the 10th BUSY cycle
    @(negedge clk);
    op = 2'd0; src_a = 32'd123; src_b = 32'd456; reg_dst = 4'd14; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_busy_stall", {63'd0, stall_req}, 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("after_flush_idle", {62'd0, stall_req, result_valid}, 64'd0);
    no_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || stall_req !== 1'b0) no_valid = 1'b0;
    end
    chk("no_valid_after_flush", {63'd0, no_valid}, 64'd1);
    chk("flush_keeps_result", {28'd0, result, reg_dst_out}, {28'd0, prev_res, prev_dst});

    // flush in DONE suppresses result_valid but the result was already loaded
    @(negedge clk);
    op = 2'd2; src_a = 32'd77; src_b = 32'd0; reg_dst = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    #1 chk("flush_done_valid", {63'd0, result_valid}, 64'd0);
    chk("flush_done_result", {28'd0, result, reg_dst_out}, {28'd0, 32'hFFFF_FFFF, 4'd2});
    @(negedge clk);
    flush = 1'b0;

    // reset at the 20th BUSY cycle
    @(negedge clk);
    op = 2'd1; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; reg_dst = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("reset_mid_busy", {result, reg_dst_out, result_valid, stall_req}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || stall_req !== 1'b0) no_valid = 1'b0;
    end
    chk("no_valid_after_reset", {63'd0, no_valid}, 64'd1);
    run_op(2'd2, 32'd9, 32'd3, 4'd4, 32'd3, 33, 1'b0);

    // randomized ops against the arithmetic reference
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  rd;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      rd = 4'($urandom);
      run_op(ro, ra, rb, rd, ref_result(ro, ra, rb), (ro[1] && rb == 0) ? 1 : 33, n[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 The block SHALL have port flush, input, 1, aborts any in-flight operation.
REQ-004 The block SHALL have port start, input, 1, request a mul/div operation from the ID/EX register outputs.
REQ-005 The block SHALL have port op, input, 2, operation select: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
REQ-006 The block SHALL have port src_a, input, 32, multiplicand or dividend (forwarded rd1).
REQ-007 The block SHALL have port src_b, input, 32, multiplier or divisor (forwarded rd2).
REQ-008 The block SHALL have port reg_dst, input, 4, destination register tag of the requesting instruction.
REQ-009 The block SHALL have port result, output, 32, operation result.
REQ-010 The block SHALL have port result_valid, output, 1, one-cycle pulse marking result and reg_dst_out valid.
REQ-011 The block SHALL have port reg_dst_out, output, 4, tag captured at start.
REQ-012 The block SHALL have port stall_req, output, 1, pipeline stall request to the PC, IF/ID and ID/EX registers.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 In IDLE, when start=1 and flush=0, the block SHALL capture op, src_a, src_b and reg_dst.
- On that capture, it SHALL clear the 6-bit iteration counter and go to BUSY.
REQ-015 DIVU or REMU with src_b=0 SHALL go from IDLE directly to DONE.
- In that case result SHALL be 0xFFFFFFFF for DIVU and src_a for REMU.
REQ-016 BUSY SHALL last exactly 32 cycles, with one iteration per cycle.
- Multiply SHALL be unsigned shift-add into a 64-bit product.
- Divide SHALL be unsigned restoring with a 32-bit quotient and remainder.
REQ-017 After the 32nd BUSY iteration the FSM SHALL go to DONE.
REQ-018 DONE SHALL last one cycle, then return to IDLE unconditionally.
- start in DONE SHALL be ignored.
REQ-019 The result mapping SHALL be:
- MUL = product[31:0]
- MULHU = product[63:32]
- DIVU = quotient
- REMU = remainder
REQ-020 result and reg_dst_out SHALL be registered.
- They SHALL update on entry to DONE.
- They SHALL hold their value until the next entry to DONE.
REQ-021 result_valid SHALL equal (state==DONE) && !flush.
REQ-022 stall_req SHALL equal (state==IDLE && start && !flush) || state==BUSY.
- It SHALL be 0 in DONE so the pipeline advances and captures the result.
REQ-023 Latency SHALL be: start accepted at cycle T gives result_valid at T+33, or at T+1 for divide-by-zero.
REQ-024 start while in BUSY SHALL be ignored; the operands captured at T SHALL be used throughout.
REQ-025 flush=1 in any state SHALL force the next state to IDLE and SHALL suppress result_valid in that cycle.
- result and reg_dst_out SHALL NOT be modified by flush.
REQ-026 flush and start together in IDLE SHALL leave the block in IDLE with stall_req=0.
REQ-027 The block SHALL have no wrap-around: the counter SHALL saturate its use at 31, and terminal detection SHALL be count==31 in BUSY.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force:
- state to IDLE
- counter to 0
- result to 0x00000000
- reg_dst_out to 4'd0
- result_valid to 0
- stall_req to 0
REQ-029 Reset asserted mid-BUSY SHALL discard the operation; after release, no result_valid SHALL occur until a new start.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- MUL, src_a=7, src_b=6, reg_dst=3, start at T -> stall_req=1 for T..T+32, result_valid at T+33, result=42, reg_dst_out=3.
- MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE at T+33; a repeat with MUL gives result=0x00000001.
- DIVU 100/7 -> result=14; REMU 100/7 -> result=2; both at T+33.
- DIVU 5/0 -> result=0xFFFFFFFF at T+1 with stall_req=1 only in cycle T; REMU 5/0 -> result=5.
- MUL started, flush=1 at 10th BUSY cycle -> IDLE next cycle, stall_req=0, no result_valid, result keeps its prior value.
- rst_n low at 20th BUSY cycle -> all outputs 0 immediately; after release, start DIVU 9/3 -> result=3 at T+33.
